// File: rtl/uart_rx_if.sv
// uart_rx_if: signal bundle between the UART receiver and its user.
//   i_rx           serial line into the receiver (idles high)
//   o_frame        last correctly received byte
//   o_valid        one-cycle strobe: o_frame updated this cycle
//   o_frame_error  one-cycle strobe: stop bit sampled low
//   o_busy         receiver is not idle
// Modports: slave = receiver side, master = line driver / byte consumer side.
interface uart_rx_if;
    logic       i_rx;
    logic [7:0] o_frame;
    logic       o_valid;
    logic       o_frame_error;
    logic       o_busy;

    modport master (
        output i_rx,
        input  o_frame,
        input  o_valid,
        input  o_frame_error,
        input  o_busy
    );

    modport slave (
        input  i_rx,
        output o_frame,
        output o_valid,
        output o_frame_error,
        output o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: simplex 8N1 UART receiver, LSB first.
//   The serial input is brought through a 2-flop synchroniser, the start bit is
//   re-checked at mid-bit, then each data bit and the stop bit are sampled at
//   mid-bit. A good byte is presented on o_frame with a one-cycle o_valid; a low
//   stop bit gives a one-cycle o_frame_error and the receiver then waits for the
//   line to return high, so a held-low line reports a single error.
// Ports:
//   CLK     system clock
//   RST     synchronous, active-high reset
//   rx_bus  uart_rx_if.slave: i_rx in; o_frame, o_valid, o_frame_error, o_busy out
module uart_rx #(
    parameter int unsigned ClockFrequency = 50_000_000,
    parameter int unsigned BaudRate       = 115200
) (
    input logic      CLK,
    input logic      RST,
    uart_rx_if.slave rx_bus
);

    localparam int unsigned TicksPerBit = ClockFrequency / BaudRate;
    localparam int unsigned HalfTicks   = TicksPerBit / 2;
    localparam int unsigned TickW       = $clog2(TicksPerBit);

    localparam logic [TickW-1:0] FullLast = TickW'(TicksPerBit - 1);
    localparam logic [TickW-1:0] HalfLast = TickW'(HalfTicks - 1);
    localparam logic [TickW-1:0] TickOne  = TickW'(1);

    if (TicksPerBit < 4) begin : g_param_check
        $error("uart_rx: ClockFrequency/BaudRate must be at least 4");
    end

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StBreak = 3'd4;

    logic             sync1_q;
    logic             rx_s_q;
    logic [2:0]       state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       frame_q, frame_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Synchroniser flops reset to the idle line level so reset never fakes a start edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_bus.i_rx;
            rx_s_q  <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        frame_d = frame_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    tick_d  = '0;
                end
            end

            StStart: begin
                if (tick_q == HalfLast) begin
                    tick_d = '0;
                    if (!rx_s_q) begin
                        state_d = StData;
                        bit_d   = 3'd0;
                    end else begin
                        // Line back high at mid start bit: treat as a glitch.
                        state_d = StIdle;
                    end
                end else begin
                    tick_d = tick_q + TickOne;
                end
            end

            StData: begin
                if (tick_q == FullLast) begin
                    tick_d  = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + TickOne;
                end
            end

            StStop: begin
                if (tick_q == FullLast) begin
                    tick_d = '0;
                    if (rx_s_q) begin
                        frame_d = shreg_q;
                        valid_d = 1'b1;
                        // Back to idle at mid stop bit so a following start edge is seen.
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    tick_d = tick_q + TickOne;
                end
            end

            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            frame_q <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_bus.o_frame       = frame_q;
    assign rx_bus.o_valid       = valid_q;
    assign rx_bus.o_frame_error = ferr_q;
    assign rx_bus.o_busy        = (state_q != StIdle);

endmodule
